// File: rtl/lc3_mem_pkg.sv
// Shared types and constants for the LC-3 memory access controller.
package lc3_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  localparam logic PORT_F = 1'b0;
  localparam logic PORT_D = 1'b1;

  localparam int unsigned ARB_RR    = 0;
  localparam int unsigned ARB_FIXED = 1;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Bundle of client-side (fetch/data) and RAM-side signals of the memory access controller.
interface mem_access_ctrl_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 16
) ();

  logic              f_req;
  logic [ADDR_W-1:0] f_addr;
  logic              f_done;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_done;
  logic [DATA_W-1:0] rdata;
  logic              err;
  logic              busy;
  logic              mem_cs;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;
  logic              mem_ready;

  // Environment side: the requesting core plus the RAM.
  modport master (
    output f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_dout, mem_ready,
    input  f_done, d_done, rdata, err, busy, mem_cs, mem_we, mem_addr, mem_din
  );

  modport slave (
    input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_dout, mem_ready,
    output f_done, d_done, rdata, err, busy, mem_cs, mem_we, mem_addr, mem_din
  );

endinterface

// File: rtl/mem_arbiter.sv
// Two-way fetch/data arbiter with a stale-request mask and round-robin or fixed priority.
module mem_arbiter
  import lc3_mem_pkg::*;
#(
  parameter int unsigned ARB_MODE = ARB_RR
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_en,
  input  logic [1:0] i_req,
  input  logic [1:0] i_mask,
  output logic       o_gnt_vld,
  output logic       o_gnt_port
);

  logic       r_last;
  logic [1:0] w_req;
  logic       w_port;

  assign w_req     = i_req & ~i_mask;
  assign o_gnt_vld = |w_req;
  assign o_gnt_port = w_port;

  always_comb begin
    w_port = w_req[PORT_F] ? PORT_F : PORT_D;
    // On a tie in round-robin mode the port that did not win last time goes first.
    if (ARB_MODE != ARB_FIXED && w_req[PORT_F] && w_req[PORT_D]) begin
      w_port = (r_last == PORT_F) ? PORT_D : PORT_F;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last <= PORT_D;
    end else if (i_en && o_gnt_vld) begin
      r_last <= w_port;
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Sequences the single-port synchronous RAM for the LC-3 core, serving fetch and LD/ST ports.
module mem_access_ctrl
  import lc3_mem_pkg::*;
#(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned TIMEOUT  = 4,
  parameter int unsigned ARB_MODE = ARB_RR
) (
  input logic               i_clk,
  input logic               i_rst_n,
  mem_access_ctrl_if.slave  io_bus
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  state_t            r_state;
  logic [ADDR_W-1:0] r_mar;
  logic [DATA_W-1:0] r_mdr;
  logic              r_we;
  logic              r_port;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_done_f;
  logic              r_done_d;
  logic              r_err;
  logic [1:0]        r_mask;

  logic              w_idle;
  logic              w_gnt_vld;
  logic              w_gnt_port;
  logic [CNT_W-1:0]  w_cnt_inc;

  assign w_idle    = (r_state == IDLE);
  assign w_cnt_inc = r_cnt + CNT_W'(1);

  mem_arbiter #(
    .ARB_MODE (ARB_MODE)
  ) u_arb (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_en       (w_idle),
    .i_req      ({io_bus.d_req, io_bus.f_req}),
    .i_mask     (r_mask),
    .o_gnt_vld  (w_gnt_vld),
    .o_gnt_port (w_gnt_port)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= IDLE;
      r_mar    <= '0;
      r_mdr    <= '0;
      r_we     <= 1'b0;
      r_port   <= PORT_F;
      r_cnt    <= '0;
      r_done_f <= 1'b0;
      r_done_d <= 1'b0;
      r_err    <= 1'b0;
      r_mask   <= '0;
    end else begin
      r_mask <= '0;
      unique case (r_state)
        IDLE: begin
          if (w_gnt_vld) begin
            r_port  <= w_gnt_port;
            r_state <= ISSUE;
            if (w_gnt_port == PORT_F) begin
              r_mar <= io_bus.f_addr;
              r_we  <= 1'b0;
            end else begin
              r_mar <= io_bus.d_addr;
              r_we  <= io_bus.d_we;
              r_mdr <= io_bus.d_wdata;
            end
          end
        end
        ISSUE: begin
          r_cnt <= '0;
          if (r_we) begin
            r_state  <= RESP;
            r_done_f <= (r_port == PORT_F);
            r_done_d <= (r_port == PORT_D);
          end else begin
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (io_bus.mem_ready) begin
            r_mdr    <= io_bus.mem_dout;
            r_state  <= RESP;
            r_done_f <= (r_port == PORT_F);
            r_done_d <= (r_port == PORT_D);
          end else begin
            r_cnt <= w_cnt_inc;
            if (w_cnt_inc == TIMEOUT_C) begin
              r_err    <= 1'b1;
              r_state  <= RESP;
              r_done_f <= (r_port == PORT_F);
              r_done_d <= (r_port == PORT_D);
            end
          end
        end
        RESP: begin
          r_done_f <= 1'b0;
          r_done_d <= 1'b0;
          r_err    <= 1'b0;
          r_state  <= IDLE;
          // The just-served port still holds req for one cycle; keep it from re-winning.
          r_mask   <= (r_port == PORT_D) ? 2'b10 : 2'b01;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign io_bus.f_done   = r_done_f;
  assign io_bus.d_done   = r_done_d;
  assign io_bus.rdata    = r_mdr;
  assign io_bus.err      = r_err;
  assign io_bus.busy     = !w_idle;
  assign io_bus.mem_cs   = (r_state == ISSUE);
  assign io_bus.mem_we   = (r_state == ISSUE) && r_we;
  assign io_bus.mem_addr = r_mar;
  assign io_bus.mem_din  = r_mdr;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed, table-driven bench for mem_access_ctrl (round-robin and fixed-priority instances).
module tb_mem_access_ctrl;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 16;
  localparam int unsigned TO = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic stall = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mem_access_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus0 ();
  mem_access_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus1 ();

  mem_access_ctrl #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TO), .ARB_MODE(0)) dut_rr (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_bus  (bus0)
  );

  mem_access_ctrl #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TO), .ARB_MODE(1)) dut_fx (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_bus  (bus1)
  );

  // The fixed-priority instance sees the same requests as the round-robin one.
  assign bus1.f_req   = bus0.f_req;
  assign bus1.f_addr  = bus0.f_addr;
  assign bus1.d_req   = bus0.d_req;
  assign bus1.d_we    = bus0.d_we;
  assign bus1.d_addr  = bus0.d_addr;
  assign bus1.d_wdata = bus0.d_wdata;

  // RAM model: write on CS+WE, read data and ready one cycle after a read CS.
  logic [DW-1:0] mem [0:65535];
  always @(posedge clk) begin
    if (bus0.mem_cs && bus0.mem_we) mem[bus0.mem_addr] <= bus0.mem_din;
    if (bus0.mem_cs && !bus0.mem_we) bus0.mem_dout <= mem[bus0.mem_addr];
    bus0.mem_ready <= bus0.mem_cs && !bus0.mem_we && !stall;
    if (bus1.mem_cs && !bus1.mem_we) bus1.mem_dout <= mem[bus1.mem_addr];
    bus1.mem_ready <= bus1.mem_cs && !bus1.mem_we && !stall;
  end

  typedef struct {
    logic          port;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          stall;
    int            exp_lat;
    logic          chk_rd;
    logic [DW-1:0] exp_rdata;
    logic          exp_err;
  } vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_xfer(input logic port, input logic we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, output int lat, output logic dport,
                         output logic [DW-1:0] rdata, output logic err, output int cs_cnt,
                         output logic [AW-1:0] cs_addr, output logic cs_we);
    if (port == 1'b0) begin
      bus0.f_req = 1'b1; bus0.f_addr = addr;
    end else begin
      bus0.d_req = 1'b1; bus0.d_we = we; bus0.d_addr = addr; bus0.d_wdata = wdata;
    end
    lat = -1; cs_cnt = 0; dport = 1'bx; rdata = 'x; err = 1'bx; cs_addr = 'x; cs_we = 1'bx;
    for (int k = 1; k <= 20 && lat < 0; k++) begin
      step();
      if (bus0.mem_cs) begin
        cs_cnt++; cs_addr = bus0.mem_addr; cs_we = bus0.mem_we;
      end
      if (bus0.f_done || bus0.d_done) begin
        lat = k; dport = bus0.d_done; rdata = bus0.rdata; err = bus0.err;
        bus0.f_req = 1'b0; bus0.d_req = 1'b0;
      end
    end
    bus0.f_req = 1'b0; bus0.d_req = 1'b0;
    step();
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t          vecs [7];
    int            lat, cs_cnt, nseen, both_hi, idle_cs;
    logic          dport, err, cs_we, p0, p1, got0, got1;
    logic [DW-1:0] rdata;
    logic [AW-1:0] cs_addr;
    logic          seq [4];
    logic          fx_first, fx_got;

    vecs[0] = '{1'b1, 1'b1, 16'h3000, 16'h1234, 1'b0, 2, 1'b1, 16'h1234, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 16'h3000, 16'h0000, 1'b0, 3, 1'b1, 16'h1234, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 16'h4000, 16'hBEEF, 1'b0, 2, 1'b1, 16'hBEEF, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 16'h4000, 16'h0000, 1'b0, 3, 1'b1, 16'hBEEF, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 16'h3001, 16'h0000, 1'b1, 2 + TO, 1'b0, 16'h0000, 1'b1};
    vecs[5] = '{1'b1, 1'b0, 16'h3000, 16'h0000, 1'b0, 3, 1'b1, 16'h1234, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 16'h4000, 16'h0000, 1'b0, 3, 1'b1, 16'hBEEF, 1'b0};

    bus0.f_req = 1'b0; bus0.f_addr = '0; bus0.d_req = 1'b0; bus0.d_we = 1'b0;
    bus0.d_addr = '0; bus0.d_wdata = '0;

    // Reset and idle
    step();
    step();
    chk("rst_busy", {31'd0, bus0.busy}, 32'd0);
    chk("rst_cs_we", {30'd0, bus0.mem_cs, bus0.mem_we}, 32'd0);
    chk("rst_done_err", {29'd0, bus0.f_done, bus0.d_done, bus0.err}, 32'd0);
    chk("rst_rdata", {16'd0, bus0.rdata}, 32'd0);
    chk("rst_mem_addr", {16'd0, bus0.mem_addr}, 32'd0);
    rst_n = 1'b1;
    idle_cs = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (bus0.mem_cs || bus0.busy) idle_cs++;
    end
    chk("idle_no_activity", idle_cs, 32'd0);

    // Single transfers from the table
    foreach (vecs[i]) begin
      stall = vecs[i].stall;
      do_xfer(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata,
              lat, dport, rdata, err, cs_cnt, cs_addr, cs_we);
      stall = 1'b0;
      chk($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
      chk($sformatf("v%0d_done_port", i), {31'd0, dport}, {31'd0, vecs[i].port});
      chk($sformatf("v%0d_err", i), {31'd0, err}, {31'd0, vecs[i].exp_err});
      chk($sformatf("v%0d_cs_count", i), cs_cnt, 32'd1);
      chk($sformatf("v%0d_cs_addr", i), {16'd0, cs_addr}, {16'd0, vecs[i].addr});
      chk($sformatf("v%0d_cs_we", i), {31'd0, cs_we}, {31'd0, vecs[i].we});
      if (vecs[i].chk_rd) chk($sformatf("v%0d_rdata", i), {16'd0, rdata},
                              {16'd0, vecs[i].exp_rdata});
    end

    // Tie after a lone fetch: round-robin gives D, fixed priority gives F
    bus0.f_req = 1'b1; bus0.f_addr = 16'h3000;
    bus0.d_req = 1'b1; bus0.d_we = 1'b0; bus0.d_addr = 16'h4000;
    got0 = 1'b0; got1 = 1'b0; p0 = 1'bx; p1 = 1'bx;
    for (int k = 0; k < 10 && !(got0 && got1); k++) begin
      step();
      if (!got0 && (bus0.f_done || bus0.d_done)) begin got0 = 1'b1; p0 = bus0.d_done; end
      if (!got1 && (bus1.f_done || bus1.d_done)) begin got1 = 1'b1; p1 = bus1.d_done; end
      if (got0 && got1) begin bus0.f_req = 1'b0; bus0.d_req = 1'b0; end
    end
    bus0.f_req = 1'b0; bus0.d_req = 1'b0;
    chk("tie_rr_port", {31'd0, p0}, 32'd1);
    chk("tie_fixed_port", {31'd0, p1}, 32'd0);
    chk("tie_rr_rdata", {16'd0, bus0.rdata}, {16'd0, 16'hBEEF});
    step();
    step();
    step();

    // Continuous tie after reset: F first, then alternation, one done per grant
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    bus0.f_req = 1'b1; bus0.d_req = 1'b1;
    nseen = 0; both_hi = 0; fx_got = 1'b0; fx_first = 1'bx;
    for (int k = 0; k < 40 && nseen < 4; k++) begin
      step();
      if (bus0.f_done && bus0.d_done) both_hi++;
      if (bus0.f_done || bus0.d_done) begin seq[nseen] = bus0.d_done; nseen++; end
      if (!fx_got && (bus1.f_done || bus1.d_done)) begin fx_got = 1'b1; fx_first = bus1.d_done; end
    end
    bus0.f_req = 1'b0; bus0.d_req = 1'b0;
    chk("rr_grant_count", nseen, 32'd4);
    chk("rr_both_done", both_hi, 32'd0);
    for (int i = 0; i < 4; i++) begin
      if (i < nseen) chk($sformatf("rr_seq%0d", i), {31'd0, seq[i]}, i % 2);
    end
    chk("fixed_first_grant", {31'd0, fx_first}, 32'd0);
    step();
    step();
    step();

    // Reset while waiting on the RAM
    stall = 1'b1;
    bus0.f_req = 1'b1; bus0.f_addr = 16'h3000;
    step();
    step();
    step();
    chk("midop_busy_before", {31'd0, bus0.busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midop_cs_low", {31'd0, bus0.mem_cs}, 32'd0);
    chk("midop_idle", {31'd0, bus0.busy}, 32'd0);
    bus0.f_req = 1'b0;
    stall = 1'b0;
    step();
    rst_n = 1'b1;
    nseen = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (bus0.f_done || bus0.d_done) nseen++;
    end
    chk("midop_no_done", nseen, 32'd0);
    do_xfer(1'b0, 1'b0, 16'h3000, 16'h0000, lat, dport, rdata, err, cs_cnt, cs_addr, cs_we);
    chk("post_rst_latency", lat, 32'd3);
    chk("post_rst_rdata", {16'd0, rdata}, {16'd0, 16'h1234});
    chk("post_rst_err", {31'd0, err}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
